// File: rtl/vga_scanout.sv
// vga_scanout
// -----------
// VGA raster timing generator and output stage. Free-running x/y counters
// address the upstream pixel source; the colour it returns PIX_LATENCY ticks
// later is registered onto the connector pins together with syncs that have
// been delayed by the same amount, so sync, blanking and colour stay aligned.
// Every counter and pipeline stage advances only on a pix_en tick. pix_en is
// a clock enable with no backpressure: the upstream source must always have
// colour ready when it is sampled.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pix_en       in   pixel tick enable
//   r_in/g_in/b_in in 4 colour for the x/y presented PIX_LATENCY ticks earlier
//   x, y         out  10-bit raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   frame_start  out  one-clk pulse after the tick that wraps to (0,0)
//   vga_hsync    out  active-low hsync, aligned with the RGB pins
//   vga_vsync    out  active-low vsync, aligned with the RGB pins
//   vga_r/g/b    out  4-bit colour pins, zero while blanked
//   vga_active   out  high while the RGB pins carry a visible pixel
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_LATENCY = 1     // legal range 0..4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word layout: {hsync, vsync, active}. Idle value is syncs
    // deasserted (high) and blanked.
    localparam logic [2:0] DLY_IDLE = 3'b110;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic at_line_end;
    logic at_frame_end;

    assign at_line_end  = (x == H_LAST);
    assign at_frame_end = at_line_end && (y == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            if (at_line_end) begin
                x <= '0;
                y <= (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    // Registered so it is high in the cycle where x/y already read (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && at_frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Raw timing decode from the counters
    // ------------------------------------------------------------------
    logic       hsync_raw;
    logic       vsync_raw;
    logic       active_raw;
    logic [2:0] raw;

    assign hsync_raw  = !((x >= HS_START) && (x < HS_END));
    assign vsync_raw  = !((y >= VS_START) && (y < VS_END));
    assign active_raw = (x < H_VIS) && (y < V_VIS);
    assign raw        = {hsync_raw, vsync_raw, active_raw};

    // ------------------------------------------------------------------
    // Delay line matching the upstream pixel latency
    // ------------------------------------------------------------------
    logic [2:0] dly;

    generate
        if (PIX_LATENCY == 0) begin : g_no_delay
            assign dly = raw;
        end else begin : g_delay
            logic [2:0] stage [PIX_LATENCY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIX_LATENCY; i++) begin
                        stage[i] <= DLY_IDLE;
                    end
                end else if (pix_en) begin
                    stage[0] <= raw;
                    for (int i = 1; i < PIX_LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dly = stage[PIX_LATENCY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: one register on the pins, colour gated by active
    // ------------------------------------------------------------------
    logic dly_hsync;
    logic dly_vsync;
    logic dly_active;

    assign {dly_hsync, dly_vsync, dly_active} = dly;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hsync  <= 1'b1;
            vga_vsync  <= 1'b1;
            vga_active <= 1'b0;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
        end else if (pix_en) begin
            vga_hsync  <= dly_hsync;
            vga_vsync  <= dly_vsync;
            vga_active <= dly_active;
            vga_r      <= dly_active ? r_in : 4'h0;
            vga_g      <= dly_active ? g_in : 4'h0;
            vga_b      <= dly_active ? b_in : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  // Reduced raster so several full frames fit in a short run.
  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int LAT = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       fs;
  } exp_t;

  localparam int EW = $bits(exp_t);
  localparam exp_t RESET_EXP = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
                                 act: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0, fs: 1'b0};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [3:0] r_in = 4'h0;
  logic [3:0] g_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_active;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .frame_start(frame_start),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_active(vga_active)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  exp_t          last_exp = RESET_EXP;
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_ticks = 0;   // pix_en ticks since reset release
  bit            mode_white = 1'b0;

  function automatic exp_t got_vec();
    exp_t g;
    g.x = x; g.y = y; g.hs = vga_hsync; g.vs = vga_vsync; g.act = vga_active;
    g.r = vga_r; g.g = vga_g; g.b = vga_b; g.fs = frame_start;
    return g;
  endfunction

  task automatic check_vec(input string name, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b act=%b rgb=%h%h%h fs=%b required x=%0d y=%0d hs=%b vs=%b act=%b rgb=%h%h%h fs=%b",
               name, $time, got.x, got.y, got.hs, got.vs, got.act, got.r, got.g, got.b, got.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.r, exp.g, exp.b, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: the observable state after n ticks since reset release.
  // The pins show the raster position from LAT+1 ticks earlier.
  function automatic exp_t model(input int n, input logic [3:0] r, input logic [3:0] g,
                                 input logic [3:0] b);
    exp_t e;
    int   k, px, py;
    e = RESET_EXP;
    e.x  = 10'(n % HT);
    e.y  = 10'((n / HT) % VT);
    e.fs = (n > 0) && (n % FRAME == 0);
    if (n >= LAT + 1) begin
      k  = n - LAT - 1;
      px = k % HT;
      py = (k / HT) % VT;
      e.hs  = !((px >= HA + HF) && (px < HA + HF + HS));
      e.vs  = !((py >= VA + VF) && (py < VA + VF + VS));
      e.act = (px < HA) && (py < VA);
      e.r   = e.act ? r : 4'h0;
      e.g   = e.act ? g : 4'h0;
      e.b   = e.act ? b : 4'h0;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // One clk of stimulus. For a tick, the upstream colour is that of the
  // position presented LAT ticks ago; the expected pin state is queued.
  task automatic do_cycle(input logic en);
    int   k;
    exp_t e;
    @(negedge clk);
    pix_en = en;
    r_in = 4'($urandom); g_in = 4'($urandom); b_in = 4'($urandom);
    if (en && reset_n) begin
      k = n_ticks - LAT;
      if (mode_white) begin
        r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
      end else if (k >= 0) begin
        r_in = 4'(k % HT);
        g_in = 4'((k / HT) % VT);
      end
      e = model(n_ticks + 1, r_in, g_in, b_in);
      exp_q.push_back(EW'(e));
      n_ticks++;
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_vec("reset async", got_vec(), RESET_EXP);
    for (int i = 0; i < cycles; i++) do_cycle(1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    pix_en = 1'b0;
    n_ticks = 0;
    exp_q.delete();
    last_exp = RESET_EXP;
  endtask

  // ---------------- monitor ----------------
  int hs_run = 0;
  int vs_run = 0;
  int since_fs = 0;

  initial begin
    exp_t got, e;
    forever begin
      @(posedge clk);
      #1;
      got = got_vec();
      if (!reset_n) begin
        check_vec("reset hold", got, RESET_EXP);
        hs_run = 0; vs_run = 0; since_fs = 0;
      end else if (pix_en) begin
        if (exp_q.size() == 0) begin
          check_int("expected queue underflow", 0, 1);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check_vec("tick", got, e);
          last_exp = e;
        end
        since_fs++;
        if (frame_start) begin
          check_int("frame period ticks", since_fs, FRAME);
          since_fs = 0;
        end
        if (!vga_hsync) hs_run++;
        else begin
          if (hs_run > 0) check_int("hsync low ticks", hs_run, HS);
          hs_run = 0;
        end
        if (!vga_vsync) vs_run++;
        else begin
          if (vs_run > 0) check_int("vsync low ticks", vs_run, VS * HT);
          vs_run = 0;
        end
      end else begin
        e = last_exp;
        e.fs = 1'b0;
        check_vec("hold between ticks", got, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with pix_en high and random colour.
    pix_en = 1'b1;
    for (int i = 0; i < 6; i++) do_cycle(1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    pix_en = 1'b0;
    n_ticks = 0;
    exp_q.delete();
    last_exp = RESET_EXP;

    // First tick moves x to 1.
    do_cycle(1'b1);
    #6;
    check_int("x after first tick", int'(x), 1);

    // Continuous ticks, position-coded colour: two frames.
    for (int i = 0; i < 2 * FRAME + 19; i++) do_cycle(1'b1);

    // Constant white input: pins must be blanked outside the visible area.
    mode_white = 1'b1;
    for (int i = 0; i < FRAME + 7; i++) do_cycle(1'b1);
    mode_white = 1'b0;

    // Reset in the middle of a line (currently inside hsync).
    apply_reset(3);

    // Random pix_en duty cycle.
    for (int i = 0; i < 1000; i++) do_cycle(logic'($urandom_range(0, 1)));

    // pix_en every 4th clk for two frames.
    for (int i = 0; i < 8 * FRAME + 20; i++) do_cycle((i % 4) == 3);

    do_cycle(1'b0);
    do_cycle(1'b0);
    @(negedge clk);
    check_int("expected queue drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
